// File: rtl/control_unit_pkg.sv
// Shared ISA, ALU flag and control-unit state definitions for the 8-bit softcore.
// Opcode values double as bit indices of the one-hot ALU enable bus.
package control_unit_pkg;

  localparam logic [3:0] ISA_NOP  = 4'h0;
  localparam logic [3:0] ISA_ADD  = 4'h1;
  localparam logic [3:0] ISA_ADDI = 4'h2;
  localparam logic [3:0] ISA_SH   = 4'h3;
  localparam logic [3:0] ISA_SHI  = 4'h4;
  localparam logic [3:0] ISA_NOT  = 4'h5;
  localparam logic [3:0] ISA_AND  = 4'h6;
  localparam logic [3:0] ISA_OR   = 4'h7;
  localparam logic [3:0] ISA_XOR  = 4'h8;
  localparam logic [3:0] ISA_LD   = 4'h9;
  localparam logic [3:0] ISA_ST   = 4'hA;
  localparam logic [3:0] ISA_CMP  = 4'hB;
  localparam logic [3:0] ISA_BEQ  = 4'hC;
  localparam logic [3:0] ISA_BGT  = 4'hD;
  localparam logic [3:0] ISA_JMP  = 4'hE;
  localparam logic [3:0] ISA_HALT = 4'hF;

  localparam int ISA_INSTRUCTION_COUNT = 16;

  localparam int ALU_FLAG_EQ    = 0;
  localparam int ALU_FLAG_GT    = 1;
  localparam int ALU_FLAG_COUNT = 2;

  typedef enum logic [2:0] {
    CU_FETCH     = 3'd0,
    CU_DECODE    = 3'd1,
    CU_EXECUTE   = 3'd2,
    CU_WRITEBACK = 3'd3,
    CU_HALT      = 3'd4
  } cu_state_e;

  // CMP reuses the XOR unit so the ALU can produce EQ/GT without a writeback.
  function automatic logic [ISA_INSTRUCTION_COUNT-1:0] op_enable(input logic [3:0] opcode);
    logic [ISA_INSTRUCTION_COUNT-1:0] en;
    en = '0;
    case (opcode)
      ISA_ADD, ISA_ADDI, ISA_SH, ISA_SHI,
      ISA_NOT, ISA_AND, ISA_OR, ISA_XOR: en[opcode] = 1'b1;
      ISA_CMP:                           en[ISA_XOR] = 1'b1;
      default:                           en = '0;
    endcase
    return en;
  endfunction

  function automatic logic op_writes_acc(input logic [3:0] opcode);
    logic we;
    case (opcode)
      ISA_ADD, ISA_ADDI, ISA_SH, ISA_SHI, ISA_NOT,
      ISA_AND, ISA_OR, ISA_XOR, ISA_LD: we = 1'b1;
      default:                          we = 1'b0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/control_unit_pc_unit.sv
// Program counter: holds the PC, steps by one or adds a sign-extended 4-bit offset.
module control_unit_pc_unit #(
  parameter int                   BIT_COUNT = 8,
  parameter logic [BIT_COUNT-1:0] PC_RESET  = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 update,
  input  logic                 take_offset,
  input  logic [3:0]           offset,
  output logic [BIT_COUNT-1:0] pc
);

  logic [BIT_COUNT-1:0] pc_r;
  logic [BIT_COUNT-1:0] offset_ext_s;
  logic [BIT_COUNT-1:0] pc_next_s;

  // Next-PC select; additions wrap modulo 2^BIT_COUNT
  always_comb begin
    offset_ext_s = {{(BIT_COUNT-4){offset[3]}}, offset};
    if (take_offset) begin
      pc_next_s = pc_r + offset_ext_s;
    end else begin
      pc_next_s = pc_r + {{(BIT_COUNT-1){1'b0}}, 1'b1};
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= PC_RESET;
    end else if (update) begin
      pc_r <= pc_next_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit softcore.
// Optional retired-instruction counter enabled by CONTROL_UNIT_PERF_CNT_EN.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int                   BIT_COUNT = 8,
  parameter logic [BIT_COUNT-1:0] PC_RESET  = 8'h00
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             imem_req,
  output logic [BIT_COUNT-1:0]             imem_addr,
  input  logic                             imem_valid,
  input  logic [BIT_COUNT-1:0]             imem_data,
  input  logic [ALU_FLAG_COUNT-1:0]        alu_flags,
  output logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
  output logic [3:0]                       imm,
  output logic [3:0]                       reg_sel,
  output logic                             acc_we,
  output logic                             reg_we,
  output logic [BIT_COUNT-1:0]             pc,
  output logic                             halted
`ifdef CONTROL_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]                      retired_count
`endif
);

  cu_state_e                        state_r;
  logic [BIT_COUNT-1:0]             ir_r;
  logic [ALU_FLAG_COUNT-1:0]        flags_r;
  logic                             imem_req_r;
  logic [ISA_INSTRUCTION_COUNT-1:0] en_r;
  logic                             acc_we_r;
  logic                             reg_we_r;
  logic                             halted_r;

  logic [3:0]                       opcode_s;
  logic                             pc_update_s;
  logic                             take_s;
  logic [BIT_COUNT-1:0]             pc_s;

  assign opcode_s = ir_r[7:4];

  // Branch resolution uses only the flags latched by the last CMP
  always_comb begin
    pc_update_s = (state_r == CU_WRITEBACK) && (opcode_s != ISA_HALT);
    take_s      = 1'b0;
    case (opcode_s)
      ISA_BEQ: take_s = flags_r[ALU_FLAG_EQ];
      ISA_BGT: take_s = flags_r[ALU_FLAG_GT];
      ISA_JMP: take_s = 1'b1;
      default: take_s = 1'b0;
    endcase
  end

  control_unit_pc_unit #(
    .BIT_COUNT (BIT_COUNT),
    .PC_RESET  (PC_RESET)
  ) u_pc_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .update      (pc_update_s),
    .take_offset (take_s),
    .offset      (ir_r[3:0]),
    .pc          (pc_s)
  );

  // Sequencer FSM; every output is registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= CU_FETCH;
      ir_r       <= '0;
      flags_r    <= '0;
      imem_req_r <= 1'b0;
      en_r       <= '0;
      acc_we_r   <= 1'b0;
      reg_we_r   <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        CU_FETCH: begin
          if (imem_req_r && imem_valid) begin
            ir_r       <= imem_data;
            imem_req_r <= 1'b0;
            state_r    <= CU_DECODE;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        CU_DECODE: begin
          en_r    <= op_enable(opcode_s);
          state_r <= CU_EXECUTE;
        end
        CU_EXECUTE: begin
          en_r     <= '0;
          acc_we_r <= op_writes_acc(opcode_s);
          reg_we_r <= (opcode_s == ISA_ST);
          if (opcode_s == ISA_CMP) begin
            flags_r <= alu_flags;
          end
          state_r  <= CU_WRITEBACK;
        end
        CU_WRITEBACK: begin
          acc_we_r <= 1'b0;
          reg_we_r <= 1'b0;
          if (opcode_s == ISA_HALT) begin
            halted_r <= 1'b1;
            state_r  <= CU_HALT;
          end else begin
            imem_req_r <= 1'b1;
            state_r    <= CU_FETCH;
          end
        end
        CU_HALT: begin
          state_r <= CU_HALT;
        end
        default: begin
          state_r    <= CU_FETCH;
          imem_req_r <= 1'b0;
          en_r       <= '0;
          acc_we_r   <= 1'b0;
          reg_we_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONTROL_UNIT_PERF_CNT_EN
  logic [31:0] retired_count_r;

  // Saturating count of instructions leaving WRITEBACK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_count_r <= 32'h0000_0000;
    end else if ((state_r == CU_WRITEBACK) && (retired_count_r != 32'hFFFF_FFFF)) begin
      retired_count_r <= retired_count_r + 32'h0000_0001;
    end else begin
      retired_count_r <= retired_count_r;
    end
  end

  assign retired_count = retired_count_r;
`endif

  assign imem_req       = imem_req_r;
  assign imem_addr      = pc_s;
  assign pc             = pc_s;
  assign instruction_en = en_r;
  assign imm            = ir_r[3:0];
  assign reg_sel        = ir_r[3:0];
  assign acc_we         = acc_we_r;
  assign reg_we         = reg_we_r;
  assign halted         = halted_r;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/sequencing FSM for the 8-bit softcore.
- Drives the ALU's one-hot instruction enable bus and consumes the ALU flag outputs (EQ/GT) to resolve branches.
- Owns the program counter and the instruction-memory request handshake.
- Generates write enables for reg_acc and the register file.

Parameters:
- BIT_COUNT, 8, datapath, instruction and PC width.
- PC_RESET, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- imem_req  out  1  instruction fetch request; held until accepted.
- imem_addr  out  BIT_COUNT  fetch address, equal to pc.
- imem_valid  in  1  imem_data valid this cycle; accepted only while imem_req=1.
- imem_data  in  BIT_COUNT  instruction word: opcode [7:4], imm [3:0].
- alu_flags  in  ALU_FLAG_COUNT  ALU flags; ALU_FLAG_EQ and ALU_FLAG_GT used.
- instruction_en  out  ISA_INSTRUCTION_COUNT  one-hot ALU operation enable.
- imm  out  4  immediate field of the current instruction.
- reg_sel  out  4  register-file index (= imm) for LD/ST/ALU-register ops.
- acc_we  out  1  write ALU result / load data into reg_acc.
- reg_we  out  1  write reg_acc into the register file at reg_sel.
- pc  out  BIT_COUNT  current program counter.
- halted  out  1  high after HALT retires.

Behaviour:
- Opcode map (values fixed in param.vh): 0 NOP, 1 ADD, 2 ADDI, 3 SH, 4 SHI, 5 NOT, 6 AND, 7 OR, 8 XOR, 9 LD, A ST, B CMP, C BEQ, D BGT, E JMP, F HALT.
- ISA_* enable indices equal the opcode values, and ISA_INSTRUCTION_COUNT=16.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset, while rst_n=0 at a clk edge:
  - state=FETCH, pc=PC_RESET.
  - instruction register=0, flag register=0.
  - All outputs 0, except imem_addr=PC_RESET.
- FETCH:
  - imem_req=1.
  - When imem_valid=1, capture imem_data into the instruction register and go to DECODE.
  - Otherwise stay in FETCH. Wait latency is unbounded.
- DECODE: one cycle. Drives imm and reg_sel. instruction_en is still 0.
- EXECUTE: one cycle. instruction_en has exactly the opcode bit set. NOP, LD, ST, JMP, BEQ, BGT and HALT assert no enable bit.
- CMP:
  - In EXECUTE, asserts ISA_XOR.
  - Latches alu_flags into the flag register at the end of EXECUTE.
  - Does not write reg_acc.
- WRITEBACK:
  - ALU ops and LD: acc_we=1 for exactly one cycle.
  - ST: reg_we=1 for exactly one cycle.
  - Then pc updates and the FSM returns to FETCH.
- PC update:
  - Default: pc+1, modulo 2^BIT_COUNT (wraps 8'hFF to 8'h00).
  - BEQ: if flag EQ=1, pc = pc + sign_extend(imm).
  - BGT: if flag GT=1, pc = pc + sign_extend(imm).
  - JMP: pc = pc + sign_extend(imm).
  - Branch offsets are signed 4-bit, range -8..+7. Wrap-around is modular.
  - Offset 0 makes a tight loop on the same instruction; this is legal.
- Branches use only the registered flags from the last CMP. They never use live alu_flags.
- Flags persist across non-CMP instructions.
- HALT:
  - In WRITEBACK the FSM goes to state HALT, not FETCH.
  - halted=1 and pc is frozen; the FSM stays until reset.
- Minimum cycles per instruction: 4 when imem_valid arrives in the first FETCH cycle.
- Reset mid-operation:
  - Any in-flight fetch is abandoned and imem_req drops the next cycle.
  - No acc_we or reg_we pulse is issued.
- Invariants:
  - instruction_en is either zero or one-hot in every cycle.
  - acc_we and reg_we are never high together.
  - imem_valid while imem_req=0 is ignored.

Optional Feature:
- Macro: CONTROL_UNIT_PERF_CNT_EN.
- When defined, adds output retired_count (32 bits):
  - Cleared on reset.
  - Increments once per instruction leaving WRITEBACK, including HALT.
  - Saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter do not exist; other behaviour is identical.

Decomposition:
- Shared param.vh holds:
  - ISA_* opcode/enable indices and ISA_INSTRUCTION_COUNT.
  - ALU_FLAG_EQ, ALU_FLAG_GT and ALU_FLAG_COUNT.
  - Control-unit state encodings (CU_FETCH..CU_HALT).
- One natural sub-module: pc_unit, holding the PC register, increment, signed-offset add and branch select.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles, then release.
  - Required: pc=8'h00, imem_req=1 on the first cycle after release, all enables 0.
- ADDI fetch with wait:
  - Stimulus: imem_data=8'h23, imem_valid delayed 3 cycles.
  - Required: instruction_en has only bit 2 set for exactly one cycle, acc_we pulses once, pc becomes 8'h01.
- CMP then taken BEQ:
  - Stimulus: CMP at pc=8'h10 with alu_flags EQ=1, then BEQ imm=4'hE at pc=8'h11.
  - Required: pc becomes 8'h0F (offset -2).
- CMP then not-taken BGT:
  - Stimulus: CMP with GT=0, then BGT imm=4'h7.
  - Required: pc+1.
- ST at pc wrap:
  - Stimulus: ST imm=4'h5 at pc=8'hFF.
  - Required: reg_we one cycle with reg_sel=5, acc_we stays 0, pc wraps to 8'h00.
- HALT then reset mid-fetch:
  - Stimulus: HALT, then 10 more idle cycles; then assert rst_n=0 during a FETCH.
  - Required: halted=1, pc frozen and imem_req=0 for the 10 cycles; after reset, pc=PC_RESET with no write pulses.
